// File: rtl/sub_16_serial.sv
// Bit-serial modular subtractor: diff = r1 - r2 (mod 2^WIDTH), DIGIT bits per clock, LSB slice first,
// with valid/ready handshakes on both the operand and the result side.
module sub_16_serial #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] r1,
  input  logic [WIDTH-1:0] r2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] r_result_bus,
  output logic             borrow
);

  localparam int unsigned NSLICE = WIDTH / DIGIT;
  localparam int unsigned KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t           r_state;
  state_t           w_next_state;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [KW-1:0]    r_k;
  logic             r_borrow;

  logic [DIGIT-1:0] w_a_slice;
  logic [DIGIT-1:0] w_b_slice;
  logic [DIGIT:0]   w_sum;
  logic             w_last;
  logic             w_accept;

  assign w_accept = (r_state == IDLE) && in_valid;
  assign w_last   = (r_k == KW'(NSLICE - 1));
  assign borrow   = r_borrow;

  // Slice select is an unrolled mux so every part-select index is a constant.
  always_comb begin
    w_a_slice = '0;
    w_b_slice = '0;
    for (int unsigned i = 0; i < NSLICE; i++) begin
      if (r_k == KW'(i)) begin
        w_a_slice = r_a[i*DIGIT +: DIGIT];
        w_b_slice = r_b[i*DIGIT +: DIGIT];
      end
    end
    w_sum = {1'b0, w_a_slice} + {1'b0, ~w_b_slice} + {{DIGIT{1'b0}}, r_carry};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE: if (in_valid)  w_next_state = CALC;
      CALC: if (w_last)    w_next_state = DONE;
      DONE: if (out_ready) w_next_state = IDLE;
      default:             w_next_state = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a          <= '0;
      r_b          <= '0;
      r_carry      <= 1'b0;
      r_k          <= '0;
      r_borrow     <= 1'b0;
      r_result_bus <= '0;
    end else if (w_accept) begin
      // Carry-in of 1 completes the two's-complement negation of r2.
      r_a     <= r1;
      r_b     <= r2;
      r_carry <= 1'b1;
      r_k     <= '0;
    end else if (r_state == CALC) begin
      for (int unsigned i = 0; i < NSLICE; i++) begin
        if (r_k == KW'(i)) begin
          r_result_bus[i*DIGIT +: DIGIT] <= w_sum[DIGIT-1:0];
        end
      end
      r_carry <= w_sum[DIGIT];
      r_k     <= r_k + 1'b1;
      if (w_last) begin
        r_borrow <= ~w_sum[DIGIT];
      end
    end
  end

endmodule
